// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift engine: operation codes and FSM state encoding.
package usr_pkg;

    // Operation codes carried on i_mode and latched at command accept.
    typedef enum logic [2:0] {
        USR_NOP  = 3'b000,
        USR_LOAD = 3'b001,
        USR_SHL  = 3'b010,
        USR_SHR  = 3'b011,
        USR_SAR  = 3'b100,
        USR_ROL  = 3'b101,
        USR_ROR  = 3'b110,
        USR_SIN  = 3'b111
    } usr_mode_e;

    // Command FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } usr_state_e;

endpackage

// File: rtl/usr_step_unit.sv
// Combinational step of the shift engine: shifts one word by k positions (0..STEP)
// in the requested mode. With USR_SOUT_EN defined it also reports the last bit
// that left the word during this step.
module usr_step_unit
    import usr_pkg::*;
#(
    parameter int N    = 8,
    parameter int STEP = 1,
    parameter int KW   = $clog2(STEP + 1)
) (
    input  logic [N-1:0]  word_i,
    input  logic [KW-1:0] k_i,
    input  usr_mode_e     mode_i,
    input  logic          sin_i,
`ifdef USR_SOUT_EN
    output logic          sout_o,
`endif
    output logic [N-1:0]  word_o
);

    // Single-position move of a word for the given mode.
    function automatic logic [N-1:0] shift1(input logic [N-1:0] w, input usr_mode_e m,
                                            input logic s);
        logic [N-1:0] r;
        r = w;
        case (m)
            USR_SHL: r = {w[N-2:0], 1'b0};
            USR_SHR: r = {1'b0, w[N-1:1]};
            USR_SAR: r = {w[N-1], w[N-1:1]};
            USR_ROL: r = {w[N-2:0], w[N-1]};
            USR_ROR: r = {w[0], w[N-1:1]};
            USR_SIN: r = {w[N-2:0], s};
            default: r = w;
        endcase
        return r;
    endfunction

`ifdef USR_SOUT_EN
    // Bit that leaves the word during a single-position move.
    function automatic logic out1(input logic [N-1:0] w, input usr_mode_e m);
        logic b;
        b = 1'b0;
        case (m)
            USR_SHL, USR_ROL, USR_SIN: b = w[N-1];
            USR_SHR, USR_SAR, USR_ROR: b = w[0];
            default:                   b = 1'b0;
        endcase
        return b;
    endfunction
`endif

    logic [N-1:0] word_s;
`ifdef USR_SOUT_EN
    logic         sout_s;
`endif

    // Chain of STEP single-position moves, the first k of which are applied.
    always_comb begin
        word_s = word_i;
`ifdef USR_SOUT_EN
        sout_s = 1'b0;
`endif
        for (int j = 0; j < STEP; j++) begin
            if (j < int'(k_i)) begin
`ifdef USR_SOUT_EN
                sout_s = out1(word_s, mode_i);
`endif
                word_s = shift1(word_s, mode_i, sin_i);
            end else begin
                word_s = word_s;
            end
        end
    end

    assign word_o = word_s;
`ifdef USR_SOUT_EN
    assign sout_o = sout_s;
`endif

endmodule

// File: rtl/universal_shift_engine.sv
// Universal shift engine: N-bit register with load, shift, rotate and serial-in
// operations by a programmable amount, STEP positions per RUN cycle, driven by a
// start/busy/done handshake. Optional feature macro: USR_SOUT_EN (adds o_sout).
module universal_shift_engine
    import usr_pkg::*;
#(
    parameter int N    = 8,
    parameter int STEP = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [2:0]         i_mode,
    input  logic [$clog2(N):0] i_amt,
    input  logic [N-1:0]       i_d,
    input  logic               i_sin,
    output logic [N-1:0]       o_q,
    output logic               o_busy,
`ifdef USR_SOUT_EN
    output logic               o_sout,
`endif
    output logic               o_done
);

    localparam int AW = $clog2(N) + 1;
    localparam int KW = $clog2(STEP + 1);

    usr_state_e    state_q, state_d;
    usr_mode_e     mode_q, mode_d;
    logic [AW-1:0] rem_q, rem_d;
    logic [N-1:0]  q_q, q_d;
`ifdef USR_SOUT_EN
    logic          sout_q, sout_d;
    logic          step_sout_s;
`endif

    logic [KW-1:0] k_s;
    logic [N-1:0]  step_word_s;
    logic [AW-1:0] amt_mod_s;
    logic [AW-1:0] rem_left_s;

    // Rotations wrap after N positions, so only the residue needs to run.
    assign amt_mod_s  = i_amt % AW'(N);
    assign rem_left_s = rem_q - AW'(k_s);

    // Positions moved this RUN cycle: one in serial-in mode, else min(STEP, rem).
    always_comb begin
        k_s = KW'(1);
        if (mode_q == USR_SIN) begin
            k_s = KW'(1);
        end else if (rem_q < AW'(STEP)) begin
            k_s = KW'(rem_q);
        end else begin
            k_s = KW'(STEP);
        end
    end

    usr_step_unit #(
        .N    (N),
        .STEP (STEP),
        .KW   (KW)
    ) u_step (
        .word_i (q_q),
        .k_i    (k_s),
        .mode_i (mode_q),
        .sin_i  (i_sin),
`ifdef USR_SOUT_EN
        .sout_o (step_sout_s),
`endif
        .word_o (step_word_s)
    );

    // Next-state logic: command accept in IDLE/DONE, stepping in RUN.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        q_d     = q_q;
`ifdef USR_SOUT_EN
        sout_d  = sout_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    mode_d = usr_mode_e'(i_mode);
                    rem_d  = AW'(0);
                    case (usr_mode_e'(i_mode))
                        USR_NOP: begin
                            state_d = ST_DONE;
                        end
                        USR_LOAD: begin
                            q_d     = i_d;
                            state_d = ST_DONE;
                        end
                        USR_ROL, USR_ROR: begin
                            if (amt_mod_s == AW'(0)) begin
                                state_d = ST_DONE;
                            end else begin
                                rem_d   = amt_mod_s;
                                state_d = ST_RUN;
                            end
                        end
                        default: begin
                            if (i_amt == AW'(0)) begin
                                state_d = ST_DONE;
                            end else begin
                                rem_d   = i_amt;
                                state_d = ST_RUN;
                            end
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                q_d    = step_word_s;
                rem_d  = rem_left_s;
`ifdef USR_SOUT_EN
                sout_d = step_sout_s;
`endif
                if (rem_left_s == AW'(0)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = AW'(0);
            end
        endcase
    end

    // State, mode, remaining count and data registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            mode_q  <= USR_NOP;
            rem_q   <= AW'(0);
            q_q     <= N'(0);
`ifdef USR_SOUT_EN
            sout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
`ifdef USR_SOUT_EN
            sout_q  <= sout_d;
`endif
        end
    end

    assign o_q    = q_q;
    assign o_busy = (state_q == ST_RUN);
    assign o_done = (state_q == ST_DONE);
`ifdef USR_SOUT_EN
    assign o_sout = sout_q;
`endif

endmodule

// File: tb/tb_universal_shift_engine.sv
// Directed bench for universal_shift_engine: one N=8/STEP=1 instance and one N=8/STEP=4 instance.
module tb_universal_shift_engine;
    import usr_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0;
    logic       start2 = 1'b0;
    logic [2:0] mode = 3'b000;
    logic [3:0] amt = 4'd0;
    logic [7:0] d = 8'h00;
    logic       sin = 1'b0;
    logic [7:0] q1, q2;
    logic       busy1, busy2, done1, done2;
`ifdef USR_SOUT_EN
    logic       sout1, sout2;
`endif

    int checks = 0;
    int failures = 0;
    int bc;

    always #5 clk = ~clk;

    universal_shift_engine #(.N(8), .STEP(1)) u1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_mode(mode), .i_amt(amt),
        .i_d(d), .i_sin(sin), .o_q(q1), .o_busy(busy1),
`ifdef USR_SOUT_EN
        .o_sout(sout1),
`endif
        .o_done(done1)
    );

    universal_shift_engine #(.N(8), .STEP(4)) u2 (
        .i_clk(clk), .i_rst(rst), .i_start(start2), .i_mode(mode), .i_amt(amt),
        .i_d(d), .i_sin(sin), .o_q(q2), .o_busy(busy2),
`ifdef USR_SOUT_EN
        .o_sout(sout2),
`endif
        .o_done(done2)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic dn(input bit sel);
        return sel ? done2 : done1;
    endfunction

    function automatic logic bz(input bit sel);
        return sel ? busy2 : busy1;
    endfunction

    // Drive a one-cycle command; returns #1 after the accept edge.
    task automatic issue(input bit sel, input logic [2:0] m, input logic [3:0] a, input logic [7:0] dd);
        mode = m;
        amt  = a;
        d    = dd;
        if (sel) start2 = 1'b1;
        else     start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    // Count busy samples until done appears, with a cycle bound.
    task automatic wait_done(input bit sel, output int busy_cnt);
        int n;
        busy_cnt = 0;
        n = 0;
        while (!dn(sel) && n < 50) begin
            if (bz(sel)) busy_cnt++;
            @(posedge clk);
            #1;
            n++;
        end
        check_val("done_seen", 32'(dn(sel)), 32'd1);
    endtask

    task automatic idle_tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_q",    32'(q1),    32'h00);
        check_val("rst_busy", 32'(busy1), 32'd0);
        check_val("rst_done", 32'(done1), 32'd0);
        rst = 1'b0;
        idle_tick();

        // 1: LOAD
        issue(1'b0, USR_LOAD, 4'd0, 8'hA5);
        check_val("load_q",     32'(q1),    32'hA5);
        check_val("load_done",  32'(done1), 32'd1);
        check_val("load_busy",  32'(busy1), 32'd0);
        idle_tick();
        check_val("load_done_pulse", 32'(done1), 32'd0);
        check_val("load_busy_after", 32'(busy1), 32'd0);

        // 2: SAR 3 and SHR 3 from 81
        issue(1'b0, USR_LOAD, 4'd0, 8'h81);
        idle_tick();
        issue(1'b0, USR_SAR, 4'd3, 8'h00);
        wait_done(1'b0, bc);
        check_val("sar_busy_cycles", 32'(bc), 32'd3);
        check_val("sar_q", 32'(q1), 32'hF0);
        idle_tick();
        check_val("sar_done_pulse", 32'(done1), 32'd0);
        issue(1'b0, USR_LOAD, 4'd0, 8'h81);
        idle_tick();
        issue(1'b0, USR_SHR, 4'd3, 8'h00);
        wait_done(1'b0, bc);
        check_val("shr_busy_cycles", 32'(bc), 32'd3);
        check_val("shr_q", 32'(q1), 32'h10);
        idle_tick();

        // 3: ROL 9 (effective 1), ROR 8 (effective 0)
        issue(1'b0, USR_LOAD, 4'd0, 8'h81);
        idle_tick();
        issue(1'b0, USR_ROL, 4'd9, 8'h00);
        wait_done(1'b0, bc);
        check_val("rol_busy_cycles", 32'(bc), 32'd1);
        check_val("rol_q", 32'(q1), 32'h03);
`ifdef USR_SOUT_EN
        check_val("rol_sout", 32'(sout1), 32'd1);
`endif
        idle_tick();
        issue(1'b0, USR_LOAD, 4'd0, 8'h81);
        idle_tick();
        issue(1'b0, USR_ROR, 4'd8, 8'h00);
        check_val("ror8_done", 32'(done1), 32'd1);
        check_val("ror8_busy", 32'(busy1), 32'd0);
        check_val("ror8_q",    32'(q1),    32'h81);
        idle_tick();

        // 4: STEP=4, SHL 6 from FF, start during RUN ignored
        issue(1'b1, USR_LOAD, 4'd0, 8'hFF);
        idle_tick();
        issue(1'b1, USR_SHL, 4'd6, 8'h00);
        check_val("s4_busy0", 32'(busy2), 32'd1);
        mode = USR_LOAD;
        amt = 4'd0;
        d = 8'h00;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        check_val("s4_q_mid",  32'(q2),    32'hF0);
        check_val("s4_busy1",  32'(busy2), 32'd1);
        idle_tick();
        check_val("s4_done",   32'(done2), 32'd1);
        check_val("s4_busy2",  32'(busy2), 32'd0);
        check_val("s4_q",      32'(q2),    32'hC0);
        idle_tick();
        check_val("s4_idle",   32'(done2), 32'd0);
        check_val("s4_q_hold", 32'(q2),    32'hC0);

        // 5: SIN 4 with 1,0,1,1
        issue(1'b0, USR_LOAD, 4'd0, 8'h00);
        idle_tick();
        issue(1'b0, USR_SIN, 4'd4, 8'h00);
        sin = 1'b1; idle_tick();
        sin = 1'b0; idle_tick();
        sin = 1'b1; idle_tick();
        sin = 1'b1; idle_tick();
        sin = 1'b0;
        check_val("sin_done", 32'(done1), 32'd1);
        check_val("sin_q",    32'(q1),    32'h0B);
        idle_tick();

        // 6: reset mid-RUN, then back-to-back accept from DONE
        issue(1'b0, USR_SHL, 4'd5, 8'h00);
        idle_tick();
        check_val("mid_busy", 32'(busy1), 32'd1);
        rst = 1'b1;
        idle_tick();
        rst = 1'b0;
        check_val("mrst_q",    32'(q1),    32'h00);
        check_val("mrst_busy", 32'(busy1), 32'd0);
        check_val("mrst_done", 32'(done1), 32'd0);
        issue(1'b0, USR_LOAD, 4'd0, 8'h0F);
        check_val("b2b_done0", 32'(done1), 32'd1);
        issue(1'b0, USR_SHL, 4'd2, 8'h00);
        check_val("b2b_busy", 32'(busy1), 32'd1);
        wait_done(1'b0, bc);
        check_val("b2b_busy_cycles", 32'(bc), 32'd2);
        check_val("b2b_q", 32'(q1), 32'h3C);
        idle_tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
